// File: rtl/dnlink_pkg.sv
// dnlink_pkg: sequencer states, frame layout constants and the odd-parity helper
package dnlink_pkg;

    localparam int DL_DATA_BITS  = 15;
    localparam int DL_FRAME_BITS = 1 + 2 * (DL_DATA_BITS + 1);
    localparam int DL_W1_PAR     = 16;
    localparam int DL_W2_FIRST   = 17;
    localparam int DL_W2_PAR     = 32;

    typedef enum logic [1:0] {DL_IDLE, DL_ARMED, DL_SEND, DL_DONE} dl_state_e;

    // Returned bit makes the total count of ones (data plus parity) odd.
    function automatic logic odd_par(input logic [DL_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/dnlink_shifter.sv
// dnlink_shifter: frame buffer loaded from the holding words, presents the bit at the frame index
// DNLINK_PARITY_EN: bits 16/32 carry generated odd parity; otherwise the latched bit-16 of each word
module dnlink_shifter
    import dnlink_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_,
    input  logic                    load,
    input  logic [DL_DATA_BITS+1:1] w1,
    input  logic [DL_DATA_BITS+1:1] w2,
    input  logic [5:0]              idx,
    output logic                    bit_out
);

    logic [DL_FRAME_BITS-1:0] frame;
    logic                     p1;
    logic                     p2;

`ifdef DNLINK_PARITY_EN
    assign p1 = odd_par(w1[DL_DATA_BITS:1]);
    assign p2 = odd_par(w2[DL_DATA_BITS:1]);
`else
    assign p1 = w1[DL_DATA_BITS+1];
    assign p2 = w2[DL_DATA_BITS+1];
`endif

    // Capture the whole frame in transmit order (bit 0 at the MSB) when a frame starts.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) frame <= '0;
        else if (load) frame <= {w1[DL_DATA_BITS+1], w1[DL_DATA_BITS:1], p1, w2[DL_DATA_BITS:1], p2};
    end

    assign bit_out = frame[6'(DL_FRAME_BITS - 1) - idx];

endmodule

// File: rtl/dnlink_sequencer.sv
// dnlink_sequencer: holds the ch34/ch35 downlink words and serialises one 33-bit frame per start strobe
// DNLINK_PARITY_EN selects generated parity in the shifter (see dnlink_shifter)
module dnlink_sequencer
    import dnlink_pkg::*;
#(
    parameter int DATA_BITS  = DL_DATA_BITS,
    parameter int FRAME_BITS = 1 + 2 * (DATA_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 wr_ch34,
    input  logic                 wr_ch35,
    input  logic [DATA_BITS+1:1] chwl,
    input  logic                 dk_start,
    input  logic                 bit_tick,
    output logic                 dk_data,
    output logic                 bsync_,
    output logic                 dk_end,
    output logic                 downrupt,
    output logic                 underrun,
    output logic                 busy,
    output logic [5:0]           dk_ctr
);

    dl_state_e            state;
    dl_state_e            state_nx;
    logic [DATA_BITS+1:1] h34;
    logic [DATA_BITS+1:1] h35;
    logic                 f34;
    logic                 f35;
    logic                 sync_pulse;
    logic                 urun_pulse;
    logic                 start_ok;
    logic                 tick_ok;
    logic                 last;
    logic                 frame_bit;

    assign start_ok = dk_start && (state == DL_IDLE || state == DL_ARMED);
    assign tick_ok  = bit_tick && state == DL_SEND;
    assign last     = dk_ctr == 6'(FRAME_BITS - 1);

    // State register; reset aborts any frame without an end pulse.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= DL_IDLE;
        else state <= state_nx;
    end

    // Next state and the outputs decoded from state and the pulse registers.
    always_comb begin
        state_nx = state;
        state_nx = state == DL_SEND ? (tick_ok && last ? DL_DONE : DL_SEND)
                 : start_ok ? DL_SEND : (f34 && f35) ? DL_ARMED : DL_IDLE;
        busy     = state == DL_SEND;
        dk_end   = state == DL_DONE;
        downrupt = state == DL_DONE;
        dk_data  = state == DL_SEND && frame_bit;
        bsync_   = !sync_pulse;
        underrun = urun_pulse;
    end

    // Holding words with loaded flags, bit counter and the one-cycle sync/underrun pulses.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            h34        <= '0;
            h35        <= '0;
            f34        <= 1'b0;
            f35        <= 1'b0;
            sync_pulse <= 1'b0;
            urun_pulse <= 1'b0;
            dk_ctr     <= '0;
        end else begin
            if (wr_ch34) h34 <= chwl;
            if (wr_ch35) h35 <= chwl;
            f34        <= wr_ch34 || (f34 && !start_ok);
            f35        <= wr_ch35 || (f35 && !start_ok);
            urun_pulse <= start_ok && !(f34 && f35);
            sync_pulse <= start_ok || (tick_ok && !last);
            dk_ctr     <= (start_ok || (tick_ok && last)) ? '0 : tick_ok ? dk_ctr + 6'd1 : dk_ctr;
        end
    end

    dnlink_shifter u_shifter (
        .clk    (clk),
        .rst_   (rst_),
        .load   (start_ok),
        .w1     (h34),
        .w2     (h35),
        .idx    (dk_ctr),
        .bit_out(frame_bit)
    );

endmodule

// File: tb/tb_dnlink_sequencer.sv
// tb_dnlink_sequencer: directed and random stimulus checked every cycle against a frame-level model
module tb_dnlink_sequencer;
    import dnlink_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic        wr_ch34;
    logic        wr_ch35;
    logic [16:1] chwl;
    logic        dk_start;
    logic        bit_tick;
    logic        dk_data;
    logic        bsync_;
    logic        dk_end;
    logic        downrupt;
    logic        underrun;
    logic        busy;
    logic [5:0]  dk_ctr;

    int n_chk = 0;
    int n_fail = 0;
    bit started = 1'b0;

    bit [0:32]   m_frame;
    bit [0:32]   cap;
    int          m_idx;
    int          ncap;
    int          nend;
    bit          m_busy, m_end, m_sync, m_urun, m_f34, m_f35;
    logic [16:1] m34, m35;

`ifdef DNLINK_PARITY_EN
    localparam logic [32:0] F1_EXP  = {1'b1, 14'd0, 1'b1, 1'b0, 15'h7FFF, 1'b0};
    localparam logic [15:0] U_EXP   = 16'h0001;
    localparam logic        W2T_EXP = 1'b0;
`else
    localparam logic [32:0] F1_EXP  = {1'b1, 14'd0, 1'b1, 1'b1, 15'h7FFF, 1'b0};
    localparam logic [15:0] U_EXP   = 16'h0000;
    localparam logic        W2T_EXP = 1'b1;
`endif

    dnlink_sequencer dut (
        .clk     (clk),
        .rst_    (rst_),
        .wr_ch34 (wr_ch34),
        .wr_ch35 (wr_ch35),
        .chwl    (chwl),
        .dk_start(dk_start),
        .bit_tick(bit_tick),
        .dk_data (dk_data),
        .bsync_  (bsync_),
        .dk_end  (dk_end),
        .downrupt(downrupt),
        .underrun(underrun),
        .busy    (busy),
        .dk_ctr  (dk_ctr)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Frame contents straight from the bit-order rules: order bit, word 1 MSB first, tail, word 2, tail.
    function automatic bit [0:32] build(input logic [16:1] w1, input logic [16:1] w2);
        bit [0:32] f;
        int o1 = 0;
        int o2 = 0;
        f[0] = w1[16];
        for (int k = 0; k < 15; k++) begin
            f[1 + k]  = w1[15 - k];
            f[17 + k] = w2[15 - k];
            o1 += int'(w1[15 - k]);
            o2 += int'(w2[15 - k]);
        end
`ifdef DNLINK_PARITY_EN
        f[16] = (o1 % 2 == 0);
        f[32] = (o2 % 2 == 0);
`else
        f[16] = w1[16];
        f[32] = w2[16];
`endif
        return f;
    endfunction

    // Each falling edge: compare outputs with the model, then advance the model with the inputs
    // that the next rising edge will sample.
    initial forever begin
        @(negedge clk);
        if (!rst_) begin
            m_frame = '0;
            m_idx = 0;
            {m_busy, m_end, m_sync, m_urun, m_f34, m_f35} = '0;
            m34 = '0;
            m35 = '0;
        end
        if (started)
            chk("cycle", 64'({dk_data, bsync_, dk_end, downrupt, underrun, busy, dk_ctr}),
                64'({m_busy && m_frame[m_idx], !m_sync, m_end, m_end, m_urun, m_busy, 6'(m_idx)}));
        if (rst_) begin
            if (!bsync_) begin
                if (ncap < 33) cap[ncap] = dk_data;
                ncap++;
            end
            if (dk_end) nend++;
            m_sync = 1'b0;
            m_urun = 1'b0;
            if (m_busy) begin
                if (bit_tick) begin
                    if (m_idx == 32) begin
                        m_busy = 1'b0;
                        m_end = 1'b1;
                        m_idx = 0;
                    end else begin
                        m_idx++;
                        m_sync = 1'b1;
                    end
                end
            end else if (m_end) begin
                m_end = 1'b0;
            end else if (dk_start) begin
                m_frame = build(m34, m35);
                m_busy = 1'b1;
                m_idx = 0;
                m_sync = 1'b1;
                m_urun = !(m_f34 && m_f35);
                m_f34 = 1'b0;
                m_f35 = 1'b0;
            end
            if (wr_ch34) begin m34 = chwl; m_f34 = 1'b1; end
            if (wr_ch35) begin m35 = chwl; m_f35 = 1'b1; end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input bit ch, input logic [16:1] v);
        chwl = v;
        wr_ch34 = !ch;
        wr_ch35 = ch;
        step();
        wr_ch34 = 1'b0;
        wr_ch35 = 1'b0;
    endtask

    task automatic start();
        dk_start = 1'b1;
        step();
        dk_start = 1'b0;
    endtask

    task automatic tick();
        bit_tick = 1'b1;
        step();
        bit_tick = 1'b0;
        step(3);
    endtask

    task automatic send(input int restart_at);
        for (int i = 0; i < 33; i++) begin
            if (i == restart_at) start();
            tick();
        end
        step(2);
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        step(2);
        rst_ = 1'b1;
        step();
    endtask

    initial begin
        {wr_ch34, wr_ch35, dk_start, bit_tick} = '0;
        chwl = '0;
        ncap = 0;
        nend = 0;
        #1 rst_ = 1'b0;
        step(2);
        chk("reset_outputs", 64'({dk_data, bsync_, dk_end, downrupt, underrun, busy, dk_ctr}), 64'(12'h400));
        chk("reset_state", 64'(dut.state), 64'(DL_IDLE));
        started = 1'b1;
        rst_ = 1'b1;
        step();

        // Basic frame, explicit end-pulse timing.
        wr(0, 16'h8001);
        wr(1, 16'h7FFF);
        ncap = 0;
        nend = 0;
        start();
        for (int i = 0; i < 32; i++) tick();
        bit_tick = 1'b1;
        step();
        bit_tick = 1'b0;
        @(negedge clk);
        chk("end_pulse", 64'({dk_end, downrupt, busy, dk_ctr}), 64'(9'b110_000000));
        @(negedge clk);
        chk("end_clear", 64'({dk_end, downrupt}), 64'd0);
        step();
        chk("f1_bits", 64'(cap), 64'(F1_EXP));
        chk("f1_syncs", 64'(ncap), 64'd33);
        chk("f1_ends", 64'(nend), 64'd1);

        // Only ch34 written: underrun, ch35 sent as zeros.
        do_reset();
        wr(0, 16'h8001);
        ncap = 0;
        nend = 0;
        start();
        @(negedge clk);
        chk("underrun_pulse", 64'(underrun), 64'd1);
        step();
        send(-1);
        chk("u_w2_bits", 64'(cap[17:32]), 64'(U_EXP));
        chk("u_ends", 64'(nend), 64'd1);

        // Start strobe at bit 10 is ignored.
        wr(0, 16'h4321);
        wr(1, 16'h2AAA);
        ncap = 0;
        nend = 0;
        start();
        send(10);
        chk("restart_syncs", 64'(ncap), 64'd33);
        chk("restart_ends", 64'(nend), 64'd1);

        // Write coincident with start: frame uses old value, new one waits for the next frame.
        wr(0, 16'h0003);
        wr(1, 16'h1234);
        ncap = 0;
        nend = 0;
        chwl = 16'h0005;
        wr_ch34 = 1'b1;
        dk_start = 1'b1;
        step();
        wr_ch34 = 1'b0;
        dk_start = 1'b0;
        send(-1);
        chk("coinc_first", 64'(cap[1:15]), 64'h0003);
        wr(1, 16'h0001);
        ncap = 0;
        nend = 0;
        start();
        @(negedge clk);
        chk("coinc_no_underrun", 64'(underrun), 64'd0);
        step();
        send(-1);
        chk("coinc_second", 64'(cap[1:15]), 64'h0005);

        // Asynchronous reset at bit 20.
        wr(0, 16'h8765);
        wr(1, 16'h0F0F);
        ncap = 0;
        nend = 0;
        start();
        for (int i = 0; i < 20; i++) tick();
        chk("at_bit20", 64'(dk_ctr), 64'd20);
        #2 rst_ = 1'b0;
        #1;
        chk("async_reset", 64'({dk_data, bsync_, dk_end, downrupt, underrun, busy, dk_ctr}), 64'(12'h400));
        step();
        rst_ = 1'b1;
        step(3);
        chk("abort_ends", 64'(nend), 64'd0);
        chk("idle_after_reset", 64'(dut.state), 64'(DL_IDLE));
        wr(0, 16'h1111);
        wr(1, 16'h2222);
        step();
        chk("armed", 64'(dut.state), 64'(DL_ARMED));

        // Word 2 with bit 16 set and all-ones data: tail bit shows the build option.
        wr(1, 16'hFFFF);
        ncap = 0;
        nend = 0;
        start();
        send(-1);
        chk("w2_tail_bit", 64'(cap[32]), 64'(W2T_EXP));

        // Random traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            wr_ch34  = $urandom_range(0, 24) == 0;
            wr_ch35  = $urandom_range(0, 24) == 0;
            chwl     = 16'($urandom);
            dk_start = $urandom_range(0, 30) == 0;
            bit_tick = $urandom_range(0, 2) == 0;
            rst_     = $urandom_range(0, 1999) != 0;
            step();
        end
        {wr_ch34, wr_ch35, dk_start, bit_tick} = '0;
        rst_ = 1'b1;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
